// File: rtl/sha_spi_host.sv
// SPI host for the uPcoin SHA-256 slave. It shifts one 512-bit block out on sck/sdi,
// waits for done, then clocks the 256-bit digest back in on sdo.
module sha_spi_host #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [511:0] message,
  output logic         busy,
  output logic [255:0] hash,
  output logic         hash_valid,
  output logic         timeout,
  output logic         sck,
  output logic         sdi,
  input  logic         sdo,
  output logic         block_load,
  output logic         message_load,
  input  logic         done,
  output logic [2:0]   fsm_state
);

  // Handshake: start is sampled only in IDLE; busy is high from acceptance until IDLE
  // is re-entered; hash_valid is a level that holds until the next acceptance or reset.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX_LOW    = 3'd1,
    TX_HIGH   = 3'd2,
    WAIT_DONE = 3'd3,
    RX_HIGH   = 3'd4,
    RX_LOW    = 3'd5
  } state_t;

  localparam logic [7:0]  PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t         state;
  logic [7:0]     phase_cnt;
  logic [9:0]     tx_cnt;
  logic [8:0]     rx_cnt;
  logic [15:0]    to_cnt;
  logic [511:0]   tx_sr;
  logic [255:0]   rx_sr;
  logic           done_s1;
  logic           done_s2;
  logic           phase_end;

  assign phase_end = (phase_cnt == PHASE_LAST);
  assign fsm_state = state;
  // Zeros shift in behind the block, so sdi settles to 0 once all 512 bits have gone.
  assign sdi       = tx_sr[511];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      to_cnt       <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      done_s1      <= 1'b0;
      done_s2      <= 1'b0;
      busy         <= 1'b0;
      hash         <= '0;
      hash_valid   <= 1'b0;
      timeout      <= 1'b0;
      sck          <= 1'b0;
      block_load   <= 1'b0;
      message_load <= 1'b0;
    end else begin
      done_s1 <= done;
      done_s2 <= done_s1;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr        <= message;
            tx_cnt       <= '0;
            phase_cnt    <= '0;
            busy         <= 1'b1;
            block_load   <= 1'b1;
            message_load <= 1'b1;
            hash_valid   <= 1'b0;
            state        <= TX_LOW;
          end
        end
        TX_LOW: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sck       <= 1'b1;
            state     <= TX_HIGH;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        TX_HIGH: begin
          if (phase_end) begin
            phase_cnt <= '0;
            sck       <= 1'b0;
            tx_sr     <= {tx_sr[510:0], 1'b0};
            tx_cnt    <= tx_cnt + 10'd1;
            if (tx_cnt == 10'd511) begin
              block_load   <= 1'b0;
              message_load <= 1'b0;
              to_cnt       <= '0;
              state        <= WAIT_DONE;
            end else begin
              state <= TX_LOW;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          // done is checked first so it wins a tie with expiry.
          if (done_s2) begin
            rx_cnt    <= '0;
            phase_cnt <= '0;
            sck       <= 1'b1;
            state     <= RX_HIGH;
          end else if (to_cnt == TO_LAST) begin
            timeout    <= 1'b1;
            busy       <= 1'b0;
            hash_valid <= 1'b0;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RX_HIGH: begin
          if (phase_end) begin
            rx_sr     <= {rx_sr[254:0], sdo};
            phase_cnt <= '0;
            sck       <= 1'b0;
            state     <= RX_LOW;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        RX_LOW: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (rx_cnt == 9'd255) begin
              hash       <= rx_sr;
              hash_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              rx_cnt <= rx_cnt + 9'd1;
              sck    <= 1'b1;
              state  <= RX_HIGH;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_spi_host.sv
// Bench for sha_spi_host: a behavioural SPI slave, a cycle-timeline model of the
// expected outputs, and directed plus randomized transfers on CLK_DIV=2 and CLK_DIV=1 hosts.
module tb_sha_spi_host;

  localparam int TO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic done = 1'b0;
  logic sdo = 1'b0;
  logic sel = 1'b0;
  logic [511:0] message = '0;

  logic a_busy, a_hv, a_to, a_sck, a_sdi, a_bl, a_ml;
  logic b_busy, b_hv, b_to, b_sck, b_sdi, b_bl, b_ml;
  logic [255:0] a_hash, b_hash;
  logic [2:0] a_state, b_state;

  sha_spi_host #(.CLK_DIV(2), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel), .message(message),
    .busy(a_busy), .hash(a_hash), .hash_valid(a_hv), .timeout(a_to),
    .sck(a_sck), .sdi(a_sdi), .sdo(sdo), .block_load(a_bl), .message_load(a_ml),
    .done(done & ~sel), .fsm_state(a_state)
  );

  sha_spi_host #(.CLK_DIV(1), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start & sel), .message(message),
    .busy(b_busy), .hash(b_hash), .hash_valid(b_hv), .timeout(b_to),
    .sck(b_sck), .sdi(b_sdi), .sdo(sdo), .block_load(b_bl), .message_load(b_ml),
    .done(done & sel), .fsm_state(b_state)
  );

  logic busy, hash_valid, timeout, sck, sdi, bl, ml;
  logic [255:0] hash;
  assign busy       = sel ? b_busy : a_busy;
  assign hash_valid = sel ? b_hv   : a_hv;
  assign timeout    = sel ? b_to   : a_to;
  assign sck        = sel ? b_sck  : a_sck;
  assign sdi        = sel ? b_sdi  : a_sdi;
  assign bl         = sel ? b_bl   : a_bl;
  assign ml         = sel ? b_ml   : a_ml;
  assign hash       = sel ? b_hash : a_hash;

  logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  logic [511:0] abc_msg, empty_msg;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
      if (bad >= 50) begin
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  endtask

  function automatic int cd_of();
    return sel ? 1 : 2;
  endfunction

  // Behavioural slave: captures sdi on sck rise, returns digest bits after each sck fall.
  logic [255:0] slv_digest = '0;
  logic [511:0] cap = '0;
  int cap_n = 0;
  int rx_idx = 0;

  always @(posedge sck) if (bl) begin
    cap = {cap[510:0], sdi};
    cap_n++;
  end

  always @(negedge sck) if (done) begin
    rx_idx++;
    #1;
    if (rx_idx < 256) sdo = slv_digest[255 - rx_idx];
  end

  // Timeline model: mode 0 idle, 1 sending, 2 waiting for done, 3 receiving; m_t counts
  // cycles since the mode was entered.
  int m_mode = 0;
  int m_t = 0;
  logic m_hv = 1'b0;
  logic m_to = 1'b0;
  logic [255:0] m_hash = '0;
  logic [511:0] m_msg = '0;
  logic [1:0] dh = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_t = 0; m_hv = 1'b0; m_to = 1'b0; m_hash = '0; m_msg = '0; dh = '0;
    end else begin
      logic seen;
      seen = dh[1];
      dh = {dh[0], done};
      m_to = 1'b0;
      case (m_mode)
        0: if (start) begin m_mode = 1; m_t = 0; m_msg = message; m_hv = 1'b0; end
        1: begin
          m_t++;
          if (m_t == 1024 * cd_of()) begin m_mode = 2; m_t = 0; end
        end
        2: begin
          m_t++;
          if (seen) begin m_mode = 3; m_t = 0; end
          else if (m_t == TO) begin m_mode = 0; m_to = 1'b1; end
        end
        3: begin
          m_t++;
          if (m_t == 512 * cd_of()) begin m_mode = 0; m_hv = 1'b1; m_hash = slv_digest; end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic e_sck, e_sdi, e_busy, e_bl;
    int cd;
    cd = cd_of();
    e_sck = 1'b0; e_sdi = 1'b0; e_busy = 1'b0; e_bl = 1'b0;
    case (m_mode)
      1: begin
        e_busy = 1'b1; e_bl = 1'b1;
        e_sck = ((m_t / cd) % 2) == 1;
        e_sdi = m_msg[511 - m_t / (2 * cd)];
      end
      2: e_busy = 1'b1;
      3: begin
        e_busy = 1'b1;
        e_sck = ((m_t / cd) % 2) == 0;
      end
      default: ;
    endcase
    check("ctrl", 256'({sck, sdi, busy, bl, ml, hash_valid, timeout}),
          256'({e_sck, e_sdi, e_busy, e_bl, e_bl, m_hv, m_to}));
    check("hash", hash, m_hash);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic select_dut(input logic s);
    reset_n = 1'b0;
    tick();
    sel = s;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic launch(input logic [511:0] msg);
    message = msg;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs a transfer already accepted on the previous edge. delay<0: slave never answers.
  task automatic finish_xfer(input logic [511:0] msg, input logic [255:0] dig, input int delay,
                             input bit hold_next, input logic [511:0] next_msg);
    int n;
    int cd;
    bit exp_to;
    bit bound_hit;
    cd = cd_of();
    cap = '0; cap_n = 0; rx_idx = 0; sdo = 1'b0;
    slv_digest = dig;
    n = 0;
    while (bl && n < 5000) begin tick(); n++; end
    check("tx_len", 256'(n), 256'(1024 * cd));
    check("tx_bits_hi", cap[511:256], msg[511:256]);
    check("tx_bits_lo", cap[255:0], msg[255:0]);
    check("tx_count", 256'(cap_n), 256'(512));
    exp_to = (delay < 0) || (delay + 3 > TO);
    n = 0;
    bound_hit = 1'b0;
    while (!hash_valid && !timeout) begin
      if (n >= 4000) begin bound_hit = 1'b1; break; end
      if (delay >= 0 && n == delay) begin sdo = dig[255]; rx_idx = 0; done = 1'b1; end
      if (hold_next && n == delay + 100) begin message = ~msg; start = 1'b1; end
      if (hold_next && n == delay + 101) start = 1'b0;
      if (hold_next && n == delay + 200) begin message = next_msg; start = 1'b1; end
      tick();
      n++;
    end
    check("wait_bound", 256'(bound_hit), 256'(0));
    if (exp_to) begin
      check("to_lat", 256'(n), 256'(TO));
      check("to_flags", 256'({timeout, busy, hash_valid, sck}), 256'(4'b1000));
      tick();
      check("to_pulse", 256'(timeout), 256'(0));
    end else begin
      check("rx_lat", 256'(n), 256'(delay + 3 + 512 * cd));
      check("rx_hash", hash, dig);
      check("rx_flags", 256'({hash_valid, busy, timeout, sck}), 256'(4'b1000));
    end
    done = 1'b0;
    sdo = 1'b0;
  endtask

  initial begin
    logic [511:0] rmsg, rmsg2;
    logic [255:0] rdig;
    int n;
    abc_msg = '0;
    abc_msg[511:480] = 32'h61626380;
    abc_msg[7:0] = 8'h18;
    empty_msg = '0;
    empty_msg[511] = 1'b1;

    #1 reset_n = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", 256'({busy, hash_valid, timeout, sck, sdi, bl, ml}), 256'(0));
    check("reset_hash", hash, 256'(0));
    reset_n = 1'b1;
    tick();

    launch(abc_msg);
    finish_xfer(abc_msg, ABC_D, 20, 1'b0, '0);
    check("abc_digest", hash, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    select_dut(1'b1);
    launch(empty_msg);
    finish_xfer(empty_msg, EMPTY_D, 5, 1'b0, '0);
    check("empty_digest", hash, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    select_dut(1'b0);

    launch(abc_msg);
    finish_xfer(abc_msg, ABC_D, -1, 1'b0, '0);

    launch(abc_msg);
    finish_xfer(abc_msg, ABC_D, 97, 1'b0, '0);
    launch(empty_msg);
    finish_xfer(empty_msg, EMPTY_D, 98, 1'b0, '0);

    for (int i = 0; i < 16; i++) rmsg[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) rdig[i*32 +: 32] = $urandom;
    launch(rmsg);
    finish_xfer(rmsg, rdig, 10, 1'b1, empty_msg);
    tick();
    start = 1'b0;
    check("reaccept", 256'({busy, hash_valid, bl}), 256'(3'b101));
    finish_xfer(empty_msg, EMPTY_D, 30, 1'b0, '0);

    launch(abc_msg);
    cap = '0; cap_n = 0;
    n = 0;
    while (cap_n < 300 && n < 5000) begin tick(); n++; end
    check("bit300_reached", 256'(cap_n), 256'(300));
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ctrl", 256'({busy, hash_valid, timeout, sck, sdi, bl, ml}), 256'(0));
    check("midreset_hash", hash, 256'(0));
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    launch(abc_msg);
    finish_xfer(abc_msg, ABC_D, 40, 1'b0, '0);

    for (int k = 0; k < 4; k++) begin
      select_dut(1'($urandom_range(0, 1)));
      for (int i = 0; i < 16; i++) rmsg2[i*32 +: 32] = $urandom;
      for (int i = 0; i < 8; i++) rdig[i*32 +: 32] = $urandom;
      launch(rmsg2);
      finish_xfer(rmsg2, rdig, int'($urandom_range(0, 90)), 1'b0, '0);
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
